// File: rtl/cond_sweep_ctrl_pkg.sv
// cond_sweep_ctrl_pkg: shared FSM state encoding and default sweep parameters
package cond_sweep_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;
    localparam int NIN_DEF    = 4;
    localparam int SETTLE_DEF = 1;
endpackage

// File: rtl/cond_sweep_cmp.sv
// cond_sweep_cmp: table compare and lowest-mismatch encoder for the optional self-check
module cond_sweep_cmp #(
    parameter int NIN = 4
) (
    input  logic [2**NIN-1:0] table_i,
    input  logic [2**NIN-1:0] expect_i,
    output logic              pass_o,
    output logic [NIN-1:0]    idx_o
);
    assign pass_o = (table_i == expect_i);
    // walk from the top so the lowest mismatching index is the one that sticks
    always_comb begin
        idx_o = '0;
        for (int i = 2**NIN-1; i >= 0; i--)
            if (table_i[i] != expect_i[i]) idx_o = NIN'(i);
    end
endmodule

// File: rtl/cond_sweep_ctrl.sv
// cond_sweep_ctrl: sweeps all input vectors into a condition block and captures its truth table (optional self-check: COND_SWEEP_CHECK_EN)
module cond_sweep_ctrl
    import cond_sweep_ctrl_pkg::*;
#(
    parameter int NIN    = NIN_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              y_i,
    output logic [NIN-1:0]    vec_o,
    output logic              busy,
    output logic              done,
    output logic [2**NIN-1:0] table_o
`ifdef COND_SWEEP_CHECK_EN
    ,
    input  logic [2**NIN-1:0] expect_i,
    output logic              pass_o,
    output logic [NIN-1:0]    fail_idx
`endif
);
    localparam int CW = (SETTLE == 0) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CW-1:0]  SETTLE_C = CW'(SETTLE);
    localparam logic [NIN-1:0] VEC_LAST = '1;

    state_e              state_q, state_d;
    logic [NIN-1:0]      vec_q, vec_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2**NIN-1:0]   table_q, table_d;
    logic                accept;

    assign accept  = (state_q == IDLE) && start && !abort;
    assign vec_o   = vec_q;
    assign table_o = table_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

    // state, vector, hold counter and captured table registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            table_q <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
        end
    end

    // next-state: an abort drops straight to IDLE without capturing the current vector
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = HOLD;
                vec_d   = '0;
                table_d = '0;
                cnt_d   = SETTLE_C;
            end
            HOLD: begin
                if (abort) state_d = IDLE;
                else if (cnt_q == '0) state_d = SAMPLE;
                else cnt_d = cnt_q - 1'b1;
            end
            SAMPLE: begin
                if (abort) state_d = IDLE;
                else begin
                    table_d[vec_q] = y_i;
                    if (vec_q == VEC_LAST) state_d = DONE;
                    else begin
                        vec_d   = vec_q + 1'b1;
                        cnt_d   = SETTLE_C;
                        state_d = HOLD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef COND_SWEEP_CHECK_EN
    logic           cmp_pass;
    logic [NIN-1:0] cmp_idx, fidx_q;
    logic           pass_q;

    cond_sweep_cmp #(.NIN(NIN)) u_cmp (
        .table_i  (table_d),
        .expect_i (expect_i),
        .pass_o   (cmp_pass),
        .idx_o    (cmp_idx)
    );

    assign pass_o   = pass_q;
    assign fail_idx = fidx_q;

    // verdict latched from the final table on entry to DONE, cleared by the next accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= 1'b0;
            fidx_q <= '0;
        end else if (accept) begin
            pass_q <= 1'b0;
            fidx_q <= '0;
        end else if (state_q == SAMPLE && state_d == DONE) begin
            pass_q <= cmp_pass;
            fidx_q <= cmp_idx;
        end
    end
`endif
endmodule
